// File: rtl/avg_encode_pkg.sv
// Shared AVG definitions: instruction opcodes, encoder command codes and encoder FSM states.
// The AVG decoder imports the same opcodes, so both sides agree on the instruction format.
package avg_pkg;

   localparam logic [2:0] OP_VCTR = 3'b000;
   localparam logic [2:0] OP_HALT = 3'b001;
   localparam logic [2:0] OP_SVEC = 3'b010;
   localparam logic [2:0] OP_STAT = 3'b011;
   localparam logic [2:0] OP_SCAL = 3'b011;
   localparam logic [2:0] OP_CNTR = 3'b100;
   localparam logic [2:0] OP_JSR  = 3'b101;
   localparam logic [2:0] OP_RTS  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   typedef enum logic [3:0] {
      CmdVec,
      CmdStat,
      CmdScal,
      CmdCntr,
      CmdJsr,
      CmdJmp,
      CmdRts,
      CmdHalt
   } avg_cmd_t;

   typedef enum logic [1:0] {
      StIdle,
      StWr0,
      StWr1
   } avg_enc_state_t;

endpackage

// File: rtl/avg_encode_if.sv
// Drawing-command handshake between the display-list builder and the AVG encoder.
interface avg_encode_if;
   import avg_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   avg_cmd_t           cmd_op;
   logic signed [12:0] cmd_dx;
   logic signed [12:0] cmd_dy;
   logic [2:0]         cmd_zfield;
   logic               cmd_force_long;
   logic [7:0]         cmd_z;
   logic [2:0]         cmd_color;
   logic [7:0]         cmd_lin;
   logic [2:0]         cmd_bin;
   logic [15:0]        cmd_addr;

   modport master (
      output cmd_valid, cmd_op, cmd_dx, cmd_dy, cmd_zfield, cmd_force_long,
             cmd_z, cmd_color, cmd_lin, cmd_bin, cmd_addr,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dx, cmd_dy, cmd_zfield, cmd_force_long,
             cmd_z, cmd_color, cmd_lin, cmd_bin, cmd_addr,
      output cmd_ready
   );

endinterface

// File: rtl/avg_encode_pack.sv
// Combinational packer: one drawing command into one or two AVG instruction words.
module avg_pack
   import avg_pkg::*;
(
   input  avg_cmd_t           op_i,
   input  logic signed [12:0] dx_i,
   input  logic signed [12:0] dy_i,
   input  logic [2:0]         zfield_i,
   input  logic               force_long_i,
   input  logic [7:0]         z_i,
   input  logic [2:0]         color_i,
   input  logic [7:0]         lin_i,
   input  logic [2:0]         bin_i,
   input  logic [12:0]        addr_i,
   output logic [15:0]        word0_o,
   output logic [15:0]        word1_o,
   output logic               long_o
);

   logic dx_short, dy_short, use_svec;

   // A delta fits in 5 signed bits when bits [12:4] are all sign copies.
   assign dx_short = (&dx_i[12:4]) | ~(|dx_i[12:4]);
   assign dy_short = (&dy_i[12:4]) | ~(|dy_i[12:4]);
   assign use_svec = dx_short & dy_short & ~force_long_i;

   always_comb begin
      word0_o = '0;
      word1_o = '0;
      long_o  = 1'b0;
      case (op_i)
         CmdVec: begin
            if (use_svec) begin
               word0_o = {OP_SVEC, dy_i[4:0], zfield_i, dx_i[4:0]};
            end else begin
               word0_o = {OP_VCTR, dy_i};
               word1_o = {zfield_i, dx_i};
               long_o  = 1'b1;
            end
         end
         CmdStat: word0_o = {OP_STAT, 1'b0, 1'b0, color_i, z_i};
         CmdScal: word0_o = {OP_SCAL, 1'b1, 1'b0, bin_i, lin_i};
         CmdJsr:  word0_o = {OP_JSR, addr_i};
         CmdJmp:  word0_o = {OP_JMP, addr_i};
         CmdCntr: word0_o = {OP_CNTR, 13'h0};
         CmdRts:  word0_o = {OP_RTS, 13'h0};
         default: word0_o = {OP_HALT, 13'h0};
      endcase
   end

endmodule

// File: rtl/avg_encode.sv
// AVG command encoder: accepts commands and writes packed instruction words into vector RAM.
module avg_encode
   import avg_pkg::*;
#(
   parameter int unsigned        ADDR_W = 12,
   parameter logic [ADDR_W-1:0]  LIMIT  = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   avg_encode_if.slave       cmd,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic              busy,
   output logic              overflow,
   output logic              err_align
);

   localparam logic [ADDR_W:0] PtrOne = 1;

   logic [15:0] pk_word0, pk_word1;
   logic        pk_long;

   avg_pack u_pack (
      .op_i         (cmd.cmd_op),
      .dx_i         (cmd.cmd_dx),
      .dy_i         (cmd.cmd_dy),
      .zfield_i     (cmd.cmd_zfield),
      .force_long_i (cmd.cmd_force_long),
      .z_i          (cmd.cmd_z),
      .color_i      (cmd.cmd_color),
      .lin_i        (cmd.cmd_lin),
      .bin_i        (cmd.cmd_bin),
      .addr_i       (cmd.cmd_addr[13:1]),
      .word0_o      (pk_word0),
      .word1_o      (pk_word1),
      .long_o       (pk_long)
   );

   logic unused_addr;
   assign unused_addr = ^cmd.cmd_addr[15:14];

   avg_enc_state_t    state_q, state_d;
   // One extra bit so a write at LIMIT = all-ones leaves the pointer past the end, not at zero.
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [15:0]       word1_q, word1_d;
   logic              long_q, long_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic              overflow_q, overflow_d;
   logic              err_align_q, err_align_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              busy_q, busy_d;
   logic              hs, fits, is_jump;

   always_comb begin
      hs      = cmd.cmd_valid & cmd_ready_q & ~start;
      fits    = (wr_ptr_q + {{ADDR_W{1'b0}}, pk_long}) <= {1'b0, LIMIT};
      is_jump = (cmd.cmd_op == CmdJsr) | (cmd.cmd_op == CmdJmp);

      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      word1_d     = word1_q;
      long_d      = long_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      overflow_d  = overflow_q;
      err_align_d = 1'b0;

      if (start) begin
         state_d    = StIdle;
         wr_ptr_d   = {1'b0, start_addr};
         overflow_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (hs) begin
                  err_align_d = is_jump & cmd.cmd_addr[0];
                  if (fits) begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = wr_ptr_q[ADDR_W-1:0];
                     mem_wdata_d = pk_word0;
                     word1_d     = pk_word1;
                     long_d      = pk_long;
                     wr_ptr_d    = wr_ptr_q + PtrOne;
                     state_d     = StWr0;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end
            StWr0: begin
               if (long_q) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = wr_ptr_q[ADDR_W-1:0];
                  mem_wdata_d = word1_q;
                  wr_ptr_d    = wr_ptr_q + PtrOne;
                  state_d     = StWr1;
               end else begin
                  state_d = StIdle;
               end
            end
            StWr1:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end

      busy_d      = (state_d != StIdle);
      cmd_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         word1_q     <= '0;
         long_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         overflow_q  <= 1'b0;
         err_align_q <= 1'b0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         word1_q     <= word1_d;
         long_q      <= long_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         overflow_q  <= overflow_d;
         err_align_q <= err_align_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign cmd.cmd_ready = cmd_ready_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign wr_ptr        = wr_ptr_q[ADDR_W-1:0];
   assign busy          = busy_q;
   assign overflow      = overflow_q;
   assign err_align     = err_align_q;

endmodule

// File: tb/tb_avg_encode.sv
// Directed bench for avg_encode: inputs driven and outputs checked on the falling clock edge.
module tb_avg_encode;
   import avg_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [11:0] start_addr;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [11:0] wr_ptr;
   logic        busy, overflow, err_align;
   int          checks   = 0;
   int          failures = 0;

   avg_encode_if cmd_if ();

   avg_encode dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .cmd        (cmd_if.slave),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .wr_ptr     (wr_ptr),
      .busy       (busy),
      .overflow   (overflow),
      .err_align  (err_align)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: present one command for exactly one rising edge.
   task automatic issue(input avg_cmd_t op, input logic [12:0] dx, input logic [12:0] dy,
                        input logic [2:0] zf, input logic fl, input logic [7:0] z,
                        input logic [2:0] color, input logic [7:0] lin, input logic [2:0] bin,
                        input logic [15:0] addr);
      cmd_if.cmd_op         = op;
      cmd_if.cmd_dx         = dx;
      cmd_if.cmd_dy         = dy;
      cmd_if.cmd_zfield     = zf;
      cmd_if.cmd_force_long = fl;
      cmd_if.cmd_z          = z;
      cmd_if.cmd_color      = color;
      cmd_if.cmd_lin        = lin;
      cmd_if.cmd_bin        = bin;
      cmd_if.cmd_addr       = addr;
      cmd_if.cmd_valid      = 1'b1;
      @(negedge clk);
      cmd_if.cmd_valid      = 1'b0;
   endtask

   task automatic expect_write(input string tag, input logic [11:0] addr,
                               input logic [15:0] data, input logic align);
      chk({tag, "_we"}, 32'(mem_we), 32'd1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      chk({tag, "_data"}, 32'(mem_wdata), 32'(data));
      chk({tag, "_align"}, 32'(err_align), 32'(align));
      chk({tag, "_ready0"}, 32'(cmd_if.cmd_ready), 32'd0);
   endtask

   task automatic expect_idle(input string tag);
      chk({tag, "_idle_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_idle_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_idle_align"}, 32'(err_align), 32'd0);
   endtask

   task automatic do_start(input logic [11:0] addr);
      start      = 1'b1;
      start_addr = addr;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'd0);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_wr_ptr"}, 32'(wr_ptr), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
      chk({tag, "_err_align"}, 32'(err_align), 32'd0);
   endtask

   initial begin
      rst_n                 = 1'b0;
      start                 = 1'b0;
      start_addr            = '0;
      cmd_if.cmd_valid      = 1'b0;
      cmd_if.cmd_op         = CmdHalt;
      cmd_if.cmd_dx         = '0;
      cmd_if.cmd_dy         = '0;
      cmd_if.cmd_zfield     = '0;
      cmd_if.cmd_force_long = 1'b0;
      cmd_if.cmd_z          = '0;
      cmd_if.cmd_color      = '0;
      cmd_if.cmd_lin        = '0;
      cmd_if.cmd_bin        = '0;
      cmd_if.cmd_addr       = '0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'(cmd_if.cmd_ready), 32'd1);

      // Short vector
      do_start(12'h100);
      chk("start_wr_ptr", 32'(wr_ptr), 32'h100);
      issue(CmdVec, -13'sd2, 13'sd3, 3'd7, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      expect_write("svec", 12'h100, 16'h43FE, 1'b0);
      chk("svec_wr_ptr", 32'(wr_ptr), 32'h101);
      chk("svec_busy", 32'(busy), 32'd1);
      @(negedge clk);
      expect_idle("svec");

      // Long vector: dy=16 is out of short range
      issue(CmdVec, -13'sd16, 13'sd16, 3'd5, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      expect_write("vctr0", 12'h101, 16'h0010, 1'b0);
      @(negedge clk);
      expect_write("vctr1", 12'h102, 16'hBFF0, 1'b0);
      @(negedge clk);
      expect_idle("vctr");
      chk("vctr_wr_ptr", 32'(wr_ptr), 32'h103);

      // Single-word commands back-to-back
      issue(CmdStat, 13'h0, 13'h0, 3'd0, 1'b0, 8'h80, 3'd2, 8'h0, 3'd0, 16'h0);
      expect_write("stat", 12'h103, 16'h6280, 1'b0);
      @(negedge clk);
      expect_idle("stat");
      issue(CmdScal, 13'h0, 13'h0, 3'd0, 1'b0, 8'h0, 3'd0, 8'h40, 3'd1, 16'h0);
      expect_write("scal", 12'h104, 16'h7140, 1'b0);
      @(negedge clk);
      issue(CmdJsr, 13'h0, 13'h0, 3'd0, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0404);
      expect_write("jsr", 12'h105, 16'hA202, 1'b0);
      @(negedge clk);
      issue(CmdJmp, 13'h0, 13'h0, 3'd0, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0405);
      expect_write("jmp_odd", 12'h106, 16'hE202, 1'b1);
      @(negedge clk);
      expect_idle("jmp_odd");
      issue(CmdCntr, 13'h0, 13'h0, 3'd0, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      expect_write("cntr", 12'h107, 16'h8000, 1'b0);
      @(negedge clk);
      issue(CmdRts, 13'h0, 13'h0, 3'd0, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      expect_write("rts", 12'h108, 16'hC000, 1'b0);
      @(negedge clk);
      issue(CmdHalt, 13'h0, 13'h0, 3'd0, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      expect_write("halt", 12'h109, 16'h2000, 1'b0);
      @(negedge clk);
      chk("halt_wr_ptr", 32'(wr_ptr), 32'h10A);

      // Small deltas forced into the long form
      issue(CmdVec, 13'sd1, -13'sd1, 3'd0, 1'b1, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      expect_write("force0", 12'h10A, 16'h1FFF, 1'b0);
      @(negedge clk);
      expect_write("force1", 12'h10B, 16'h0001, 1'b0);
      @(negedge clk);

      // Fit check at the last word
      do_start(12'hFFF);
      issue(CmdVec, 13'h100, 13'h0, 3'd1, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      chk("ovf_we", 32'(mem_we), 32'd0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_wr_ptr", 32'(wr_ptr), 32'hFFF);
      chk("ovf_ready", 32'(cmd_if.cmd_ready), 32'd1);
      issue(CmdHalt, 13'h0, 13'h0, 3'd0, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      expect_write("halt_last", 12'hFFF, 16'h2000, 1'b0);
      @(negedge clk);
      issue(CmdHalt, 13'h0, 13'h0, 3'd0, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      chk("full_no_wrap_we", 32'(mem_we), 32'd0);
      chk("full_overflow", 32'(overflow), 32'd1);
      do_start(12'h200);
      chk("start_clears_ovf", 32'(overflow), 32'd0);
      chk("start_wr_ptr2", 32'(wr_ptr), 32'h200);

      // Start while the second VCTR word is pending
      issue(CmdVec, 13'h100, 13'h0, 3'd1, 1'b0, 8'h0, 3'd0, 8'h0, 3'd0, 16'h0);
      expect_write("abort_w0", 12'h200, 16'h0000, 1'b0);
      do_start(12'h300);
      expect_idle("abort");
      chk("abort_wr_ptr", 32'(wr_ptr), 32'h300);
      @(negedge clk);
      chk("abort_no_w1", 32'(mem_we), 32'd0);

      // Reset in the middle of a write
      issue(CmdStat, 13'h0, 13'h0, 3'd0, 1'b0, 8'h11, 3'd3, 8'h0, 3'd0, 16'h0);
      expect_write("pre_rst", 12'h300, 16'h6311, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst2", 32'(cmd_if.cmd_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
